// File: rtl/cache_types_pkg.sv
// Shared widths and FSM state type for the L2 <-> memory cacheline adaptor.
package cache_types_pkg;

   localparam int unsigned LINE_W  = 256;
   localparam int unsigned BEAT_W  = 64;
   localparam int unsigned BEATS   = 4;
   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned OFFS_W  = 5;
   localparam int unsigned K_W     = $clog2(BEATS);
   localparam int unsigned BEAT_SH = $clog2(BEAT_W);

   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFFS_W) - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/cacheline_adaptor.sv
// Splits L2 line reads/writes into four 64-bit memory beats and reassembles
// read beats into a full line; one-cycle resp_o pulse on completion.
module cacheline_adaptor
   import cache_types_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [LINE_W-1:0]   line_i,
   output logic [LINE_W-1:0]   line_o,
   input  logic [ADDR_W-1:0]   address_i,
   input  logic                read_i,
   input  logic                write_i,
   output logic                resp_o,
   input  logic [BEAT_W-1:0]   burst_i,
   output logic [BEAT_W-1:0]   burst_o,
   output logic [ADDR_W-1:0]   address_o,
   output logic                read_o,
   output logic                write_o,
   input  logic                resp_i
);

   state_e              state_q;
   logic [K_W-1:0]      k_q;
   logic [K_W-1:0]      k_d;
   logic [LINE_W-1:0]   wbuf_q;
   logic [LINE_W-1:0]   rline_q;
   logic [BEAT_W-1:0]   burst_q;
   logic [ADDR_W-1:0]   address_q;
   logic                read_q;
   logic                write_q;
   logic                resp_q;
   logic [BEAT_W-1:0]   next_beat_d;
   logic                last_beat_d;

   assign k_d         = k_q + K_W'(1);
   assign last_beat_d = (k_q == K_W'(BEATS - 1));
   assign next_beat_d = wbuf_q[{k_d, {BEAT_SH{1'b0}}} +: BEAT_W];

   // FSM plus all datapath registers; every output is driven from a flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         k_q       <= '0;
         wbuf_q    <= '0;
         rline_q   <= '0;
         burst_q   <= '0;
         address_q <= '0;
         read_q    <= 1'b0;
         write_q   <= 1'b0;
         resp_q    <= 1'b0;
      end else begin
         resp_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               k_q <= '0;
               if (write_i) begin
                  state_q   <= WRITE;
                  wbuf_q    <= line_i;
                  address_q <= address_i & LINE_MASK;
                  burst_q   <= line_i[BEAT_W-1:0];
                  write_q   <= 1'b1;
               end else if (read_i) begin
                  state_q   <= READ;
                  address_q <= address_i & LINE_MASK;
                  read_q    <= 1'b1;
               end
            end
            READ: begin
               if (resp_i) begin
                  rline_q[{k_q, {BEAT_SH{1'b0}}} +: BEAT_W] <= burst_i;
                  k_q <= k_d;
                  if (last_beat_d) begin
                     state_q   <= DONE;
                     read_q    <= 1'b0;
                     address_q <= '0;
                     resp_q    <= 1'b1;
                  end
               end
            end
            WRITE: begin
               if (resp_i) begin
                  k_q <= k_d;
                  // Present the following beat so it is valid on the next cycle.
                  if (last_beat_d) begin
                     state_q   <= DONE;
                     write_q   <= 1'b0;
                     address_q <= '0;
                     burst_q   <= '0;
                     resp_q    <= 1'b1;
                  end else begin
                     burst_q <= next_beat_d;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign line_o    = rline_q;
   assign burst_o   = burst_q;
   assign address_o = address_q;
   assign read_o    = read_q;
   assign write_o   = write_q;
   assign resp_o    = resp_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Randomized bench for cacheline_adaptor: a transaction-level model predicts
// every output each cycle, with literal expectations on directed cases.
module tb_cacheline_adaptor;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [255:0]  line_i = '0;
   logic [255:0]  line_o;
   logic [31:0]   address_i = '0;
   logic          read_i = 1'b0;
   logic          write_i = 1'b0;
   logic          resp_o;
   logic [63:0]   burst_i = '0;
   logic [63:0]   burst_o;
   logic [31:0]   address_o;
   logic          read_o;
   logic          write_o;
   logic          resp_i = 1'b0;

   cacheline_adaptor dut (
      .clk(clk), .rst(rst),
      .line_i(line_i), .line_o(line_o),
      .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
      .burst_i(burst_i), .burst_o(burst_o),
      .address_o(address_o), .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      else passes++;
   endtask

   // Transaction-level model: kind 0=none,1=read,2=write; beats counts 0..4,
   // beats==4 is the completion cycle.
   int            m_kind = 0;
   int            m_beats = 0;
   logic [31:0]   m_addr = '0;
   logic [255:0]  m_wline = '0;
   logic [255:0]  m_line = '0;

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_kind = 0; m_beats = 0; m_addr = '0; m_wline = '0; m_line = '0;
      end else if (m_kind == 0) begin
         if (write_i) begin
            m_kind = 2; m_beats = 0; m_addr = address_i; m_wline = line_i;
         end else if (read_i) begin
            m_kind = 1; m_beats = 0; m_addr = address_i;
         end
      end else if (m_beats == 4) begin
         m_kind = 0;
      end else if (resp_i) begin
         if (m_kind == 1) m_line[64*m_beats +: 64] = burst_i;
         m_beats++;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial forever begin
      logic        e_rd, e_wr, e_resp;
      logic [31:0] e_addr;
      logic [63:0] e_burst;
      @(negedge clk);
      if (chk_en) begin
         e_rd    = (m_kind == 1) && (m_beats < 4);
         e_wr    = (m_kind == 2) && (m_beats < 4);
         e_resp  = (m_kind != 0) && (m_beats == 4);
         e_addr  = (e_rd || e_wr) ? (m_addr / 32) * 32 : 32'd0;
         e_burst = e_wr ? m_wline[64*m_beats +: 64] : 64'd0;
         chk("read_o",    256'(read_o),    256'(e_rd));
         chk("write_o",   256'(write_o),   256'(e_wr));
         chk("resp_o",    256'(resp_o),    256'(e_resp));
         chk("address_o", 256'(address_o), 256'(e_addr));
         chk("burst_o",   256'(burst_o),   256'(e_burst));
         chk("line_o",    line_o,          m_line);
      end
   end

   int          lat;
   logic        first_rd, first_wr;
   logic [31:0] first_addr;
   logic [63:0] seen_burst [4];

   task automatic drive_mem(input int c, input logic [15:0] mask, input logic [63:0] base,
                            inout int bc);
      if (mask == 16'd0) resp_i = 1'($urandom_range(0, 1));
      else resp_i = (c < 16) ? mask[c] : 1'b1;
      burst_i = (base == 64'd0) ? {$urandom, $urandom} : base + 64'(bc);
      if (resp_i && (read_o || write_o)) begin
         if (write_o && bc < 4) seen_burst[bc] = burst_o;
         bc++;
      end
   endtask

   // One L2 transaction; lat = cycle of resp_o counted from the request cycle 0.
   task automatic do_txn(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [255:0] l, input logic [15:0] mask,
                         input logic [63:0] base, input bit hold);
      int c;
      int bc;
      bit done;
      @(posedge clk); #1;
      read_i = rd; write_i = wr; address_i = a; line_i = l;
      c = 0; bc = 0; done = 1'b0; lat = -1;
      drive_mem(c, mask, base, bc);
      while (!done && c < 300) begin
         @(posedge clk); #1;
         c++;
         if (c == 1) begin first_rd = read_o; first_wr = write_o; first_addr = address_o; end
         if (resp_o) begin
            lat = c; done = 1'b1;
            resp_i = 1'($urandom_range(0, 1));
            if (!hold) begin
               @(posedge clk); #1;
               read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
            end
         end else begin
            drive_mem(c, mask, base, bc);
         end
      end
      chk("txn_completed", 256'(done), 256'(1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] wl;
      #2 rst = 1'b1;
      chk_en = 1'b1;
      #1;
      chk("rst_read_o",  256'(read_o),  256'(0));
      chk("rst_resp_o",  256'(resp_o),  256'(0));
      chk("rst_line_o",  line_o,        256'(0));
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;

      // Back-to-back read.
      do_txn(1'b1, 1'b0, 32'h0000_1234, '0, 16'hFFFF, 64'hA0, 1'b0);
      chk("rd_lat", 256'(lat), 256'(5));
      chk("rd_addr", 256'(first_addr), 256'(32'h0000_1220));
      chk("rd_read_o", 256'(first_rd), 256'(1));
      chk("rd_line", line_o, {64'hA3, 64'hA2, 64'hA1, 64'hA0});

      // Back-to-back write.
      wl = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
      do_txn(1'b0, 1'b1, 32'h0000_8000, wl, 16'hFFFF, 64'h0, 1'b0);
      chk("wr_lat", 256'(lat), 256'(5));
      chk("wr_write_o", 256'(first_wr), 256'(1));
      for (int i = 0; i < 4; i++) chk("wr_beat", 256'(seen_burst[i]), 256'(64'hD0 + 64'(i)));
      chk("wr_keeps_line_o", line_o, {64'hA3, 64'hA2, 64'hA1, 64'hA0});

      // Read with gaps: beats on cycles 2, 5, 6, 9.
      do_txn(1'b1, 1'b0, 32'h0000_0040, '0, 16'h0264, 64'hB0, 1'b0);
      chk("gap_lat", 256'(lat), 256'(10));
      chk("gap_line", line_o, {64'hB3, 64'hB2, 64'hB1, 64'hB0});

      // Simultaneous requests: write wins, then a plain read.
      do_txn(1'b1, 1'b1, 32'h0000_0100, {4{64'h5555}}, 16'hFFFF, 64'h0, 1'b0);
      chk("both_write_o", 256'(first_wr), 256'(1));
      chk("both_read_o", 256'(first_rd), 256'(0));
      chk("both_lat", 256'(lat), 256'(5));
      do_txn(1'b1, 1'b0, 32'h0000_0120, '0, 16'hFFFF, 64'hE0, 1'b0);
      chk("after_both_lat", 256'(lat), 256'(5));
      chk("after_both_line", line_o, {64'hE3, 64'hE2, 64'hE1, 64'hE0});

      // Reset after beat 2 of a write.
      @(posedge clk); #1;
      write_i = 1'b1; line_i = wl; address_i = 32'h0000_ABCD; resp_i = 1'b0;
      @(posedge clk); #1; resp_i = 1'b1;
      @(posedge clk); #1; resp_i = 1'b1;
      @(posedge clk); #1; resp_i = 1'b0;
      chk("mid_write_o", 256'(write_o), 256'(1));
      chk("mid_burst_o", 256'(burst_o), 256'(64'hD2));
      #2 rst = 1'b1;
      #1;
      chk("abort_write_o",   256'(write_o),   256'(0));
      chk("abort_burst_o",   256'(burst_o),   256'(0));
      chk("abort_address_o", 256'(address_o), 256'(0));
      chk("abort_resp_o",    256'(resp_o),    256'(0));
      chk("abort_line_o",    line_o,          256'(0));
      write_i = 1'b0; resp_i = 1'b0;
      @(posedge clk); #3 rst = 1'b0;
      do_txn(1'b1, 1'b0, 32'h0000_2000, '0, 16'hFFFF, 64'hC0, 1'b0);
      chk("post_rst_lat", 256'(lat), 256'(5));
      chk("post_rst_line", line_o, {64'hC3, 64'hC2, 64'hC1, 64'hC0});

      // Random traffic: random kind, address, line, beat gaps and back-to-back requests.
      for (int n = 0; n < 40; n++) begin
         int unsigned kind;
         kind = $urandom_range(0, 2);
         do_txn(kind != 1, kind != 0, $urandom,
                {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0000, 64'h0,
                1'($urandom_range(0, 1)));
      end
      @(posedge clk); #1;
      read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
